// File: rtl/md_unit_if.sv
// Execute-stage multiply/divide port bundle: request side (start/op/operands)
// and the HI/LO view, busy flag and combinational read result.
interface md_unit_if;
  localparam int unsigned W = 32;

  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] out;

  modport master (output start, op, a, b, input busy, hi, lo, out);
  modport slave  (input start, op, a, b, output busy, hi, lo, out);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit holding HI/LO. The result is computed
// at start and parked in pend_*, then committed when the busy window expires.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  md_unit_if.slave  bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          busy_r, busy_nxt;
  logic [W-1:0]  hi_r, hi_nxt, lo_r, lo_nxt;
  logic [W-1:0]  pend_hi, pend_hi_nxt, pend_lo, pend_lo_nxt;

  // Multiply: signed product is the low 64 bits of the sign-extended operands.
  logic [2*W-1:0] a_sx, b_sx, prod_s, prod_u;
  assign a_sx   = {{W{bus.a[W-1]}}, bus.a};
  assign b_sx   = {{W{bus.b[W-1]}}, bus.b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {W'(0), bus.a} * {W'(0), bus.b};

  // One magnitude divider shared by DIV and DIVU; signs are restored afterwards.
  logic          div_signed, neg_a, neg_b;
  logic [W-1:0]  mag_a, mag_b, q_mag, r_mag, quot, rem;
  assign div_signed = (bus.op == OP_DIV);
  assign neg_a      = div_signed && bus.a[W-1];
  assign neg_b      = div_signed && bus.b[W-1];
  assign mag_a      = neg_a ? (W'(0) - bus.a) : bus.a;
  assign mag_b      = neg_b ? (W'(0) - bus.b) : bus.b;
  assign q_mag      = (mag_b == '0) ? '0 : (mag_a / mag_b);
  assign r_mag      = (mag_b == '0) ? '0 : (mag_a % mag_b);
  assign quot       = (neg_a ^ neg_b) ? (W'(0) - q_mag) : q_mag;
  assign rem        = neg_a ? (W'(0) - r_mag) : r_mag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy_r  <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      busy_r  <= busy_nxt;
      hi_r    <= hi_nxt;
      lo_r    <= lo_nxt;
      pend_hi <= pend_hi_nxt;
      pend_lo <= pend_lo_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    busy_nxt    = busy_r;
    hi_nxt      = hi_r;
    lo_nxt      = lo_r;
    pend_hi_nxt = pend_hi;
    pend_lo_nxt = pend_lo;
    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              pend_hi_nxt = (bus.op == OP_MULT) ? prod_s[2*W-1:W] : prod_u[2*W-1:W];
              pend_lo_nxt = (bus.op == OP_MULT) ? prod_s[W-1:0]   : prod_u[W-1:0];
              cnt_nxt     = CW'(MULT_CYCLES);
              busy_nxt    = 1'b1;
              state_nxt   = RUN;
            end
            OP_DIV, OP_DIVU: begin
              // A zero divisor re-commits the current HI/LO at the end.
              pend_hi_nxt = (bus.b == '0) ? hi_r : rem;
              pend_lo_nxt = (bus.b == '0) ? lo_r : quot;
              cnt_nxt     = CW'(DIV_CYCLES);
              busy_nxt    = 1'b1;
              state_nxt   = RUN;
            end
            OP_MTHI: hi_nxt = bus.a;
            OP_MTLO: lo_nxt = bus.a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt == CW'(1)) begin
          hi_nxt    = pend_hi;
          lo_nxt    = pend_lo;
          cnt_nxt   = '0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy = busy_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign bus.out  = (bus.op == OP_MFHI) ? hi_r :
                    (bus.op == OP_MFLO) ? lo_r : '0;
endmodule
